// File: rtl/cci_mpf_prim_tx_buffer.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_tx_buffer
//
// N-channel request buffer on the MPF path toward the FIU. Each channel has
// an independent FIFO, a registered output stage and a threshold almost-full
// toward the AFU, so the AFU can keep issuing a bounded number of requests
// after almost-full rises. FIU back-pressure is absorbed without any
// combinational path back to the AFU.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   afu_tx_valid     per-channel request valid from the AFU side
//   afu_tx_data      payloads; channel i in [i*DATA_WIDTH +: DATA_WIDTH]
//   afu_tx_almfull   per-channel almost-full toward the AFU (registered count)
//   fiu_tx_valid     per-channel registered request valid toward the FIU
//   fiu_tx_data      registered payloads toward the FIU
//   fiu_tx_almfull   per-channel almost-full from the FIU; inhibits draining
//   occupancy        per-channel entry count, $clog2(DEPTH+1) bits per slice
//   overflow_err     sticky per-channel flag: a push hit a full FIFO
// ---------------------------------------------------------------------------
module cci_mpf_prim_tx_buffer #(
  parameter int NUM_CHANNELS         = 2,
  parameter int DATA_WIDTH           = 64,
  parameter int DEPTH                = 8,
  parameter int ALM_FULL_THRESHOLD   = 2,
  parameter int ENABLE_OVERFLOW_DROP = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CHANNELS-1:0]                    afu_tx_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]         afu_tx_data,
  output logic [NUM_CHANNELS-1:0]                    afu_tx_almfull,
  output logic [NUM_CHANNELS-1:0]                    fiu_tx_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]         fiu_tx_data,
  input  logic [NUM_CHANNELS-1:0]                    fiu_tx_almfull,
  output logic [NUM_CHANNELS*$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [NUM_CHANNELS-1:0]                    overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic                  ovf_evt;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  ovf;

    // Pop depends only on the registered count, so an entry written at an
    // edge cannot leave before the following edge (no bypass path).
    assign pop     = (count != '0) && !fiu_tx_almfull[i];
    // A full FIFO still accepts a push when a pop frees a slot at that edge.
    assign push    = afu_tx_valid[i] && ((count != FULL_CNT) || pop);
    assign ovf_evt = afu_tx_valid[i] && !push;

    // ---- stage p0: FIFO storage (payload only, never reset) ----
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= afu_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // ---- stage p0: FIFO control ----
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
        if (ovf_evt) ovf <= 1'b1;
      end
    end

    // ---- stage p1: registered output toward the FIU ----
    // Output data is cleared by reset so that fiu_tx_data reads zero while
    // the buffer is held in reset; otherwise it holds until the next pop.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= pop;
        if (pop) data_p1 <= mem[rd_ptr];
      end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
      if (!reset && (ENABLE_OVERFLOW_DROP == 0) && ovf_evt)
        $error("cci_mpf_prim_tx_buffer: push into full FIFO on channel %0d", i);
    end
`endif

    assign afu_tx_almfull[i]                       = ((DEPTH - int'(count)) <= ALM_FULL_THRESHOLD);
    assign fiu_tx_valid[i]                         = vld_p1;
    assign fiu_tx_data[i*DATA_WIDTH +: DATA_WIDTH] = data_p1;
    assign occupancy[i*CW +: CW]                   = count;
    assign overflow_err[i]                         = ovf;
  end

endmodule

// File: tb/tb_cci_mpf_prim_tx_buffer.sv
module tb_cci_mpf_prim_tx_buffer;
  localparam int NC = 2;
  localparam int DW = 16;
  localparam int D  = 8;
  localparam int TH = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     afu_tx_valid;
  logic [NC*DW-1:0]  afu_tx_data;
  logic [NC-1:0]     afu_tx_almfull;
  logic [NC-1:0]     fiu_tx_valid;
  logic [NC*DW-1:0]  fiu_tx_data;
  logic [NC-1:0]     fiu_tx_almfull;
  logic [NC*CW-1:0]  occupancy;
  logic [NC-1:0]     overflow_err;

  cci_mpf_prim_tx_buffer #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .DEPTH(D),
    .ALM_FULL_THRESHOLD(TH), .ENABLE_OVERFLOW_DROP(1)
  ) dut (
    .clk(clk), .reset(reset),
    .afu_tx_valid(afu_tx_valid), .afu_tx_data(afu_tx_data),
    .afu_tx_almfull(afu_tx_almfull),
    .fiu_tx_valid(fiu_tx_valid), .fiu_tx_data(fiu_tx_data),
    .fiu_tx_almfull(fiu_tx_almfull),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: entries pushed when the bench drives an accepted request,
  // popped when the FIU side is expected to receive them.
  logic [DW-1:0] mq [NC][$];
  logic [NC-1:0] ev;
  logic [DW-1:0] ed [NC];
  logic [NC-1:0] eo;
  logic [DW-1:0] rx0 [$];
  logic [DW-1:0] rx1 [$];

  task automatic step();
    logic [NC-1:0] pop;
    logic [NC-1:0] acc;
    for (int c = 0; c < NC; c++) begin
      pop[c] = (mq[c].size() > 0) && !fiu_tx_almfull[c];
      acc[c] = afu_tx_valid[c] && ((mq[c].size() < D) || pop[c]);
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        mq[c].delete();
        ev[c] = 1'b0;
        ed[c] = '0;
        eo[c] = 1'b0;
      end else begin
        if (pop[c]) ed[c] = mq[c].pop_front();
        ev[c] = pop[c];
        if (acc[c]) mq[c].push_back(afu_tx_data[c*DW +: DW]);
        if (afu_tx_valid[c] && !acc[c]) eo[c] = 1'b1;
      end
    end
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("vld%0d", c), fiu_tx_valid[c], ev[c]);
      chk($sformatf("data%0d", c), fiu_tx_data[c*DW +: DW], ed[c]);
      chk($sformatf("occ%0d", c), occupancy[c*CW +: CW], mq[c].size());
      chk($sformatf("almfull%0d", c), afu_tx_almfull[c], (D - mq[c].size()) <= TH);
      chk($sformatf("ovf%0d", c), overflow_err[c], eo[c]);
    end
    if (fiu_tx_valid[0]) rx0.push_back(fiu_tx_data[DW-1:0]);
    if (fiu_tx_valid[1]) rx1.push_back(fiu_tx_data[2*DW-1:DW]);
  endtask

  task automatic push(input int c, input logic [DW-1:0] v);
    afu_tx_valid    = '0;
    afu_tx_valid[c] = 1'b1;
    afu_tx_data[c*DW +: DW] = v;
    step();
    afu_tx_valid = '0;
  endtask

  task automatic idle(input int n);
    afu_tx_valid = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int sent;
    int guard;
    reset          = 1'b1;
    afu_tx_valid   = '0;
    afu_tx_data    = '0;
    fiu_tx_almfull = '0;

    // Reset held for three cycles: everything zero.
    idle(3);
    chk("rst_occ", occupancy, 0);
    chk("rst_vld", fiu_tx_valid, 0);
    chk("rst_data", fiu_tx_data, 0);
    reset = 1'b0;
    idle(6);

    // Latency: valid exactly two cycles after the push cycle.
    push(0, 16'hA5A5);
    chk("lat_c1", fiu_tx_valid[0], 0);
    idle(1);
    chk("lat_c2", fiu_tx_valid[0], 1);
    chk("lat_data", fiu_tx_data[DW-1:0], 16'hA5A5);
    idle(1);
    chk("lat_c3", fiu_tx_valid[0], 0);
    chk("lat_ch1", fiu_tx_valid[1], 0);

    // Almost-full under FIU stall, then fill.
    fiu_tx_almfull[0] = 1'b1;
    for (int k = 0; k < 5; k++) push(0, 16'h0100 + k);
    chk("af_at5", afu_tx_almfull[0], 0);
    push(0, 16'h0105);
    chk("af_at6", afu_tx_almfull[0], 1);
    push(0, 16'h0106);
    push(0, 16'h0107);
    chk("full_occ", occupancy[CW-1:0], 8);
    chk("full_ovf", overflow_err[0], 0);

    // Overflow drop while stalled; flag is sticky.
    push(0, 16'h00FF);
    chk("ovf_set", overflow_err[0], 1);
    chk("ovf_occ", occupancy[CW-1:0], 8);
    idle(3);
    chk("ovf_sticky", overflow_err[0], 1);
    rx0.delete();
    fiu_tx_almfull[0] = 1'b0;
    guard = 0;
    while (rx0.size() < 8 && guard < 30) begin idle(1); guard++; end
    idle(3);
    chk("drain_cnt", rx0.size(), 8);
    for (int k = 0; k < 8 && k < rx0.size(); k++)
      chk($sformatf("drain_val%0d", k), rx0[k], 16'h0100 + k);
    chk("drain_ovf", overflow_err[0], 1);

    // Clear the sticky flag, refill, then push and pop at full together.
    reset = 1'b1;
    idle(1);
    chk("rst_ovf", overflow_err[0], 0);
    reset = 1'b0;
    fiu_tx_almfull[0] = 1'b1;
    for (int k = 0; k < 8; k++) push(0, 16'h0200 + k);
    chk("sim_pre", occupancy[CW-1:0], 8);
    fiu_tx_almfull[0] = 1'b0;
    push(0, 16'h0BEE);
    chk("sim_occ", occupancy[CW-1:0], 8);
    chk("sim_ovf", overflow_err[0], 0);
    chk("sim_vld", fiu_tx_valid[0], 1);
    chk("sim_data", fiu_tx_data[DW-1:0], 16'h0200);
    idle(12);
    chk("sim_empty", occupancy[CW-1:0], 0);

    // Wrap and ordering on ch1 with random FIU back-pressure.
    rx1.delete();
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 400) begin
      fiu_tx_almfull[1] = ($urandom_range(0, 3) == 0);
      if (mq[1].size() < 6) begin
        push(1, DW'(sent));
        sent++;
      end else begin
        idle(1);
      end
      guard++;
    end
    fiu_tx_almfull[1] = 1'b0;
    guard = 0;
    while (rx1.size() < 20 && guard < 30) begin idle(1); guard++; end
    chk("wrap_cnt", rx1.size(), 20);
    for (int k = 0; k < 20 && k < rx1.size(); k++)
      chk($sformatf("wrap_val%0d", k), rx1[k], k);

    // Reset mid-stream: in-flight entries discarded, output clears.
    fiu_tx_almfull[1] = 1'b1;
    for (int k = 0; k < 5; k++) push(1, 16'h0300 + k);
    fiu_tx_almfull[1] = 1'b0;
    idle(1);
    chk("mid_vld_pre", fiu_tx_valid[1], 1);
    reset = 1'b1;
    idle(1);
    chk("mid_vld", fiu_tx_valid[1], 0);
    chk("mid_data", fiu_tx_data[2*DW-1:DW], 0);
    chk("mid_occ", occupancy[2*CW-1:CW], 0);
    reset = 1'b0;
    idle(4);
    chk("mid_after", fiu_tx_valid[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
